// File: rtl/alu_mul_sequencer.sv
// RV32M multiply sequencer: drives the shared RV32I ALU through sign-magnitude
// conversion, 32 shift-and-add iterations and an optional 64-bit negation.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; ALU inputs released (driven to zero/ADD)
// ABS_A  | mcand <= 0 - mcand (magnitude of signed multiplicand)
// ABS_B  | lo    <= 0 - lo    (magnitude of signed multiplier)
// MUL    | one shift-and-add iteration per cycle, 32 cycles
// NEG_LO | low word of 64-bit two's complement negation
// NEG_HI | high word: ~hi + (lo was zero)
// DONE   | done pulse, result presented and captured
module alu_mul_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            alu_own,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [3:0]      alu_ctrl,
   input  logic [XLEN-1:0] alu_result,
   input  logic            alu_carry
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ABS_A  = 3'd1;
   localparam logic [2:0] S_ABS_B  = 3'd2;
   localparam logic [2:0] S_MUL    = 3'd3;
   localparam logic [2:0] S_NEG_LO = 3'd4;
   localparam logic [2:0] S_NEG_HI = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;

   logic [2:0]      state;
   logic [XLEN-1:0] mcand;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic [5:0]      cnt;
   logic            lo_zero;
   logic            neg;
   logic            sb_q;
   logic [1:0]      op_q;
   logic [XLEN-1:0] result_q;
   logic [XLEN-1:0] result_sel;

   logic start_sa;
   logic start_sb;

   assign start_sa = ((op == OP_MULH) || (op == OP_MULHSU)) && rs1[XLEN-1];
   assign start_sb = (op == OP_MULH) && rs2[XLEN-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         mcand    <= '0;
         hi       <= '0;
         lo       <= '0;
         cnt      <= '0;
         lo_zero  <= 1'b0;
         neg      <= 1'b0;
         sb_q     <= 1'b0;
         op_q     <= '0;
         result_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  mcand <= rs1;
                  lo    <= rs2;
                  hi    <= '0;
                  cnt   <= '0;
                  op_q  <= op;
                  neg   <= start_sa ^ start_sb;
                  sb_q  <= start_sb;
                  if (start_sa)      state <= S_ABS_A;
                  else if (start_sb) state <= S_ABS_B;
                  else               state <= S_MUL;
               end
            end
            S_ABS_A: begin
               mcand <= alu_result;
               state <= sb_q ? S_ABS_B : S_MUL;
            end
            S_ABS_B: begin
               lo    <= alu_result;
               state <= S_MUL;
            end
            S_MUL: begin
               // Shift the 65-bit {carry,hi,lo} right by one; the ALU sum only lands when lo[0] is set.
               if (lo[0]) {hi, lo} <= {alu_carry, alu_result, lo[XLEN-1:1]};
               else       {hi, lo} <= {1'b0, hi, lo[XLEN-1:1]};
               cnt <= cnt + 6'd1;
               if (cnt == 6'd31) state <= neg ? S_NEG_LO : S_DONE;
            end
            S_NEG_LO: begin
               lo_zero <= (lo == '0);
               lo      <= alu_result;
               state   <= S_NEG_HI;
            end
            S_NEG_HI: begin
               hi    <= alu_result;
               state <= S_DONE;
            end
            S_DONE: begin
               result_q <= result_sel;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      alu_a    = '0;
      alu_b    = '0;
      alu_ctrl = ALU_ADD;
      case (state)
         S_ABS_A: begin
            alu_b    = mcand;
            alu_ctrl = ALU_SUB;
         end
         S_ABS_B, S_NEG_LO: begin
            alu_b    = lo;
            alu_ctrl = ALU_SUB;
         end
         S_MUL: begin
            alu_a = hi;
            alu_b = mcand;
         end
         S_NEG_HI: begin
            alu_a = ~hi;
            alu_b = {{(XLEN-1){1'b0}}, lo_zero};
         end
         default: ;
      endcase
   end

   assign result_sel = (op_q == OP_MUL) ? lo : hi;
   assign result     = (state == S_DONE) ? result_sel : result_q;
   assign done       = (state == S_DONE);
   assign busy       = (state != S_IDLE);
   assign alu_own    = busy;

endmodule
